// File: rtl/tone_seq_pkg.sv
// rtl/tone_seq_pkg.sv - shared types, constants and note table for the tone sequencer
package tone_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } tone_seq_state_t;

  localparam int unsigned NUM_NOTES   = 8;
  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  // Half-period divide counts for C4..C5 at CLK_FREQ_HZ; none may be zero.
  function automatic logic [31:0] note_count(input logic [2:0] idx);
    case (idx)
      3'd0:    note_count = 32'd95556;
      3'd1:    note_count = 32'd85131;
      3'd2:    note_count = 32'd75843;
      3'd3:    note_count = 32'd71586;
      3'd4:    note_count = 32'd63776;
      3'd5:    note_count = 32'd56818;
      3'd6:    note_count = 32'd50619;
      default: note_count = 32'd47778;
    endcase
  endfunction

endpackage

// File: rtl/tone_seq_timer.sv
// rtl/tone_seq_timer.sv - loadable 32-bit down-counter timing notes and gaps
module tone_seq_timer
  import tone_seq_pkg::*;
(
  input  logic        inclk,
  input  logic        Reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        enable,
  output logic        expired
);

  logic [31:0] count;

  // Saturates at zero so an idle enable never wraps to a huge count.
  always_ff @(posedge inclk) begin
    if (!Reset) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == 32'd0);

endmodule

// File: rtl/divider_tone_sequencer.sv
// rtl/divider_tone_sequencer.sv - steps the tone divider through one scale
// Optional silent gap between notes is enabled by defining TONE_SEQ_GAP_EN.
module divider_tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 25_000_000
`ifdef TONE_SEQ_GAP_EN
  , parameter int unsigned GAP_CYCLES = 2_500_000
`endif
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [31:0] div_clk_count,
  output logic        div_reset_n,
  output logic [2:0]  note_index,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] NOTE_LOAD = NOTE_CYCLES - 1;
`ifdef TONE_SEQ_GAP_EN
  localparam logic [31:0] GAP_LOAD  = GAP_CYCLES - 1;
`endif

  tone_seq_state_t state, state_next;
  logic [2:0]  note_next;
  logic        tmr_load;
  logic [31:0] tmr_load_value;
  logic        tmr_enable;
  logic        tmr_expired;

  tone_seq_timer u_timer (
    .inclk      (inclk),
    .Reset      (Reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .enable     (tmr_enable),
    .expired    (tmr_expired)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge inclk) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      note_index    <= 3'd0;
      div_clk_count <= note_count(3'd0);
      div_reset_n   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      note_index    <= note_next;
      div_clk_count <= note_count(note_next);
      div_reset_n   <= (state_next == ST_PLAY);
      busy          <= (state_next != ST_IDLE);
      done          <= (state_next == ST_DONE);
    end
  end

  always_comb begin
    state_next     = state;
    note_next      = note_index;
    tmr_load       = 1'b0;
    tmr_load_value = NOTE_LOAD;
    tmr_enable     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next = ST_LOAD;
          note_next  = 3'd0;
        end
      end
      ST_LOAD: begin
        tmr_load   = 1'b1;
        state_next = ST_PLAY;
      end
      ST_PLAY: begin
        tmr_enable = 1'b1;
        if (tmr_expired) begin
          if ((note_index != 3'd7) || loop_en) begin
            note_next = note_index + 3'd1;
`ifdef TONE_SEQ_GAP_EN
            state_next     = ST_GAP;
            tmr_load       = 1'b1;
            tmr_load_value = GAP_LOAD;
`else
            state_next = ST_LOAD;
`endif
          end else begin
            state_next = ST_DONE;
          end
        end
      end
`ifdef TONE_SEQ_GAP_EN
      ST_GAP: begin
        tmr_enable = 1'b1;
        if (tmr_expired) begin
          state_next = ST_LOAD;
        end
      end
`endif
      ST_DONE: begin
        state_next = ST_IDLE;
        note_next  = 3'd0;
      end
      default: begin
        state_next = ST_IDLE;
        note_next  = 3'd0;
      end
    endcase

    // Abort beats everything else, including a pending note change.
    if (stop && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
      note_next  = 3'd0;
      tmr_load   = 1'b0;
      tmr_enable = 1'b0;
    end
  end

endmodule
